note_scheduler: RTL and testbench

NOTE_SCHEDULER -- requirements
Module: note_scheduler

---
 rtl/note_params.sv | 34 +++
 rtl/slot_priority_enc.sv | 22 ++
 rtl/note_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_note_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/note_params.sv
// Shared screen, strike-zone and lane constants plus scheduler state encodings.
// Imported by the note scheduler and the render path so geometry stays in one place.
package note_params;

    localparam int X_W    = 10;
    localparam int Y_W    = 12;
    localparam int LANE_W = 3;

    localparam int DEF_NUM_SLOTS     = 8;
    localparam int DEF_SPEED         = 2;
    localparam int DEF_NOTE_WIDTH    = 40;
    localparam int DEF_SCREEN_BOTTOM = 480;
    localparam int DEF_HIT_TOP       = 400;
    localparam int DEF_HIT_BOTTOM    = 440;
    localparam int DEF_LANE_PITCH    = 80;
    localparam int DEF_LANE_OFFSET   = 120;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SCROLL = 1'b1
    } sched_state_t;

    // Left edge of a note square for a given lane.
    function automatic logic [X_W-1:0] lane_to_x(
        input logic [LANE_W-1:0] lane,
        input int                pitch,
        input int                offset
    );
        int v;
        v = int'(lane) * pitch + offset;
        return v[X_W-1:0];
    endfunction

endpackage

// File: rtl/slot_priority_enc.sv
// Lowest-index set-bit finder; purely combinational, no backpressure.
// Used for both free-slot allocation and strum target selection.
module slot_priority_enc #(
    parameter  int N     = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_found = |i_req;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// Falling-note slot manager: spawns notes, scrolls them one slot per cycle on each
// frame tick, and judges strums against the strike zone; event pulses are registered (1 cycle).
module note_scheduler
    import note_params::*;
#(
    parameter int NUM_SLOTS     = DEF_NUM_SLOTS,
    parameter int SPEED         = DEF_SPEED,
    parameter int NOTE_WIDTH    = DEF_NOTE_WIDTH,
    parameter int SCREEN_BOTTOM = DEF_SCREEN_BOTTOM,
    parameter int HIT_TOP       = DEF_HIT_TOP,
    parameter int HIT_BOTTOM    = DEF_HIT_BOTTOM,
    parameter int LANE_PITCH    = DEF_LANE_PITCH,
    parameter int LANE_OFFSET   = DEF_LANE_OFFSET
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     frame_tick,
    input  logic                     spawn_valid,
    input  logic [LANE_W-1:0]        spawn_lane,
    output logic                     spawn_ready,
    input  logic                     strum,
    input  logic [LANE_W-1:0]        strum_lane,
    output logic [NUM_SLOTS-1:0]     note_active,
    output logic [X_W*NUM_SLOTS-1:0] note_x_flat,
    output logic [Y_W*NUM_SLOTS-1:0] note_y_flat,
    output logic                     hit,
    output logic                     miss,
    output logic                     bad_strum,
    output logic [15:0]              score
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SLOTS - 1);
    localparam logic [Y_W:0]     SPEED_Y   = (Y_W + 1)'(SPEED);
    localparam logic [Y_W:0]     BOTTOM_Y  = (Y_W + 1)'(SCREEN_BOTTOM);
    localparam logic [Y_W-1:0]   HIT_TOP_Y = Y_W'(HIT_TOP);
    localparam logic [Y_W-1:0]   HIT_BOT_Y = Y_W'(HIT_BOTTOM);

    // Notes wider than the lane pitch would overlap their neighbours on screen.
    if (NOTE_WIDTH > LANE_PITCH) begin : g_note_too_wide
        $error("note_scheduler: NOTE_WIDTH exceeds LANE_PITCH");
    end

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;

    logic [NUM_SLOTS-1:0]  r_active;
    logic [X_W-1:0]        r_x [NUM_SLOTS];
    logic [Y_W-1:0]        r_y [NUM_SLOTS];

    logic                  r_strum_pend;
    logic [LANE_W-1:0]     r_strum_lane;
    logic                  r_hit;
    logic                  r_miss;
    logic                  r_bad;
    logic [15:0]           r_score;

    logic                  w_idle;
    logic                  w_free_found;
    logic [IDX_W-1:0]      w_free_idx;
    logic                  w_spawn_acc;
    logic                  w_strum_eval;
    logic [LANE_W-1:0]     w_strum_lane_eff;
    logic [X_W-1:0]        w_strum_x;
    logic [NUM_SLOTS-1:0]  w_match_vec;
    logic                  w_match_found;
    logic [IDX_W-1:0]      w_match_idx;
    logic                  w_hit_evt;
    logic                  w_bad_evt;
    logic [Y_W:0]          w_scroll_sum;
    logic                  w_scroll_active;
    logic                  w_retire;

    assign w_idle = (r_state == ST_IDLE);

    slot_priority_enc #(.N(NUM_SLOTS)) u_free_enc (
        .i_req   (~r_active),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    assign spawn_ready = w_idle & w_free_found;
    assign w_spawn_acc = spawn_valid & spawn_ready;

    // A strum latched during the scroll takes precedence over a live one in the same cycle.
    assign w_strum_eval     = w_idle & (r_strum_pend | strum);
    assign w_strum_lane_eff = r_strum_pend ? r_strum_lane : strum_lane;
    assign w_strum_x        = lane_to_x(w_strum_lane_eff, LANE_PITCH, LANE_OFFSET);

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_match
        assign w_match_vec[gi] = r_active[gi]
                               && (r_x[gi] == w_strum_x)
                               && (r_y[gi] >= HIT_TOP_Y)
                               && (r_y[gi] <= HIT_BOT_Y);
    end

    slot_priority_enc #(.N(NUM_SLOTS)) u_match_enc (
        .i_req   (w_match_vec),
        .o_found (w_match_found),
        .o_idx   (w_match_idx)
    );

    assign w_hit_evt = w_strum_eval & w_match_found;
    assign w_bad_evt = w_strum_eval & ~w_match_found;

    assign w_scroll_sum    = {1'b0, r_y[r_idx]} + SPEED_Y;
    assign w_scroll_active = (r_state == ST_SCROLL) && r_active[r_idx];
    assign w_retire        = w_scroll_active && (w_scroll_sum >= BOTTOM_Y);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (frame_tick) begin
                    w_state_nxt = ST_SCROLL;
                    w_idx_nxt   = '0;
                end
            end
            ST_SCROLL: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_active     <= '0;
            r_strum_pend <= 1'b0;
            r_strum_lane <= '0;
            r_hit        <= 1'b0;
            r_miss       <= 1'b0;
            r_bad        <= 1'b0;
            r_score      <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else begin
            r_hit  <= w_hit_evt;
            r_bad  <= w_bad_evt;
            r_miss <= w_retire;

            if (w_hit_evt && (r_score != 16'hFFFF)) begin
                r_score <= r_score + 16'd1;
            end

            // One-deep latch: extra strums during a scroll are dropped.
            if (r_state == ST_SCROLL) begin
                if (strum && !r_strum_pend) begin
                    r_strum_pend <= 1'b1;
                    r_strum_lane <= strum_lane;
                end
            end else begin
                r_strum_pend <= 1'b0;
            end

            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_scroll_active && (r_idx == IDX_W'(i))) begin
                    if (w_retire) begin
                        r_active[i] <= 1'b0;
                        r_x[i]      <= '0;
                        r_y[i]      <= '0;
                    end else begin
                        r_y[i] <= w_scroll_sum[Y_W-1:0];
                    end
                end
                if (w_hit_evt && (w_match_idx == IDX_W'(i))) begin
                    r_active[i] <= 1'b0;
                    r_x[i]      <= '0;
                    r_y[i]      <= '0;
                end
                // The free slot comes from the pre-strum occupancy, so it never aliases the hit slot.
                if (w_spawn_acc && (w_free_idx == IDX_W'(i))) begin
                    r_active[i] <= 1'b1;
                    r_x[i]      <= lane_to_x(spawn_lane, LANE_PITCH, LANE_OFFSET);
                    r_y[i]      <= '0;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_flat
        assign note_x_flat[X_W*gi +: X_W] = r_x[gi];
        assign note_y_flat[Y_W*gi +: Y_W] = r_y[gi];
    end

    assign note_active = r_active;
    assign hit         = r_hit;
    assign miss        = r_miss;
    assign bad_strum   = r_bad;
    assign score       = r_score;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: event pulses go through an expected-event queue
// checked by a monitor; slot state and score are checked directly after each step.
module tb_note_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_tick;
    logic        spawn_valid;
    logic [2:0]  spawn_lane;
    logic        spawn_ready;
    logic        strum;
    logic [2:0]  strum_lane;
    logic [7:0]  note_active;
    logic [79:0] note_x_flat;
    logic [95:0] note_y_flat;
    logic        hit;
    logic        miss;
    logic        bad_strum;
    logic [15:0] score;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] EV_HIT  = 3'b100;
    localparam logic [2:0] EV_MISS = 3'b010;
    localparam logic [2:0] EV_BAD  = 3'b001;

    logic [2:0] exp_q[$];

    note_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .spawn_valid (spawn_valid),
        .spawn_lane  (spawn_lane),
        .spawn_ready (spawn_ready),
        .strum       (strum),
        .strum_lane  (strum_lane),
        .note_active (note_active),
        .note_x_flat (note_x_flat),
        .note_y_flat (note_y_flat),
        .hit         (hit),
        .miss        (miss),
        .bad_strum   (bad_strum),
        .score       (score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] x_of(input int i);
        return note_x_flat[10*i +: 10];
    endfunction

    function automatic logic [11:0] y_of(input int i);
        return note_y_flat[12*i +: 12];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic spawn(input logic [2:0] lane);
        spawn_valid = 1'b1;
        spawn_lane  = lane;
        step();
        spawn_valid = 1'b0;
    endtask

    task automatic do_strum(input logic [2:0] lane);
        strum      = 1'b1;
        strum_lane = lane;
        step();
        strum = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            repeat (9) step();
        end
    endtask

    // Monitor: every event pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (hit || miss || bad_strum)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got hit/miss/bad=%b expected none", {hit, miss, bad_strum});
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if ({hit, miss, bad_strum} !== e) begin
                    errors++;
                    $display("FAIL event: got hit/miss/bad=%b expected %b", {hit, miss, bad_strum}, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n     = 1'b0;
        frame_tick  = 1'b0;
        spawn_valid = 1'b0;
        spawn_lane  = '0;
        strum       = 1'b0;
        strum_lane  = '0;
        do_reset();

        // Reset state
        chk("rst_active", 32'(note_active), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_ready", 32'(spawn_ready), 1);
        chk("rst_pulses", 32'({hit, miss, bad_strum}), 0);
        chk("rst_x0", 32'(x_of(0)), 0);
        chk("rst_y0", 32'(y_of(0)), 0);

        // First spawn lands in slot 0
        spawn(3'd2);
        chk("spawn_active", 32'(note_active), 32'h01);
        chk("spawn_x0", 32'(x_of(0)), 280);
        chk("spawn_y0", 32'(y_of(0)), 0);
        chk("spawn_ready1", 32'(spawn_ready), 1);

        // Fill all slots, then a ninth request must be refused
        for (int l = 0; l < 7; l++) spawn(3'(l));
        chk("full_active", 32'(note_active), 32'hFF);
        chk("full_ready", 32'(spawn_ready), 0);
        chk("full_x7", 32'(x_of(7)), 600);
        spawn(3'd7);
        chk("ninth_active", 32'(note_active), 32'hFF);
        chk("ninth_x7", 32'(x_of(7)), 600);

        // Scroll to the strike zone, bad strum, then hit with a same-cycle spawn
        do_reset();
        spawn(3'd2);
        frames(200);
        chk("scroll_y0", 32'(y_of(0)), 400);
        chk("scroll_active", 32'(note_active), 32'h01);
        exp_q.push_back(EV_BAD);
        do_strum(3'd1);
        chk("bad_pulse", 32'(bad_strum), 1);
        chk("bad_active", 32'(note_active), 32'h01);
        chk("bad_score", 32'(score), 0);
        step();
        chk("bad_width", 32'(bad_strum), 0);
        exp_q.push_back(EV_HIT);
        spawn_valid = 1'b1;
        spawn_lane  = 3'd5;
        do_strum(3'd2);
        spawn_valid = 1'b0;
        chk("hit_pulse", 32'(hit), 1);
        chk("hit_score", 32'(score), 1);
        chk("hit_realloc", 32'(note_active), 32'h02);
        chk("hit_x1", 32'(x_of(1)), 520);
        step();
        chk("hit_width", 32'(hit), 0);

        // Note falls off the bottom on the 240th frame
        do_reset();
        spawn(3'd3);
        frames(239);
        chk("pre_miss_y0", 32'(y_of(0)), 478);
        chk("pre_miss_active", 32'(note_active), 32'h01);
        exp_q.push_back(EV_MISS);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        chk("miss_pulse", 32'(miss), 1);
        chk("miss_cleared", 32'(note_active), 0);
        step();
        chk("miss_width", 32'(miss), 0);
        repeat (8) step();
        chk("miss_score", 32'(score), 0);

        // Strum during a scroll is latched; a second strum and a frame tick are ignored
        do_reset();
        spawn(3'd4);
        frames(205);
        chk("latch_y0", 32'(y_of(0)), 410);
        exp_q.push_back(EV_HIT);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        do_strum(3'd4);
        frame_tick = 1'b1;
        do_strum(3'd0);
        frame_tick = 1'b0;
        repeat (6) step();
        chk("latch_not_early", 32'(hit), 0);
        step();
        chk("latch_hit", 32'(hit), 1);
        chk("latch_score", 32'(score), 1);
        chk("latch_cleared", 32'(note_active), 0);
        step();
        chk("latch_width", 32'({hit, bad_strum}), 0);

        // Reset in the middle of a scroll aborts it cleanly
        spawn(3'd0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("midrst_active", 32'(note_active), 0);
        chk("midrst_ready", 32'(spawn_ready), 1);
        chk("midrst_score", 32'(score), 0);
        repeat (10) step();

        chk("events_consumed", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
